// File: rtl/sw_debounce.sv
// sw_debounce
//   Front end for the board slide switches. Each switch bit is first
//   synchronized into clk, then debounced. The debounced vector is
//   published as sw_db, with one-cycle rise/fall pulses per bit.
//
// Ports
//   clk      in   1      system clock
//   rst      in   1      synchronous reset, active-high
//   sw       in   WIDTH  raw asynchronous switch pins
//   sw_db    out  WIDTH  debounced switch state
//   sw_rise  out  WIDTH  1-cycle pulse on a 0->1 change of sw_db
//   sw_fall  out  WIDTH  1-cycle pulse on a 1->0 change of sw_db
//   changed  out  1      1-cycle pulse, OR of all rise/fall bits
//
// Per-bit debounce state (derived, not stored):
//   state    | meaning
//   STABLE   | sync_q[i] == sw_db[i]; counter held at 0
//   PENDING  | sync_q[i] != sw_db[i]; counting consecutive disagreeing edges
module sw_debounce #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  // A single-cycle debounce still needs a 1-bit counter to exist.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;
  logic [CW-1:0]    cnt    [WIDTH];
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= '0;
      end
    end else begin
      sync_r[0] <= sw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  assign sync_q = sync_r[SYNC_STAGES-1];

  // A bit fires on the edge where it has already disagreed for
  // DEBOUNCE_CYCLES-1 edges and still disagrees.
  always_comb begin
    pending = sync_q ^ sw_db;
    fire    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fire[i] = pending[i] && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!pending[i] || fire[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Pulses are registered alongside sw_db so they coincide with its change.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_db   <= '0;
      sw_rise <= '0;
      sw_fall <= '0;
      changed <= 1'b0;
    end else begin
      sw_db   <= (sw_db & ~fire) | (sync_q & fire);
      sw_rise <= fire & sync_q;
      sw_fall <= fire & ~sync_q;
      changed <= |fire;
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;

  logic       clk;
  logic       rst;
  logic [7:0] sw;
  logic [7:0] sw_db;
  logic [7:0] sw_rise;
  logic [7:0] sw_fall;
  logic       changed;

  int errors = 0;
  int checks = 0;

  sw_debounce #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .sw_db(sw_db),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw  = 8'hFF;
    for (int e = 0; e < 3; e++) begin
      tick();
      checks++;
      if ({sw_db, sw_rise, sw_fall, changed} !== 25'd0) begin
        errors++;
        $display("FAIL reset e=%0d db=%h rise=%h fall=%h chg=%b expected all 0",
                 e, sw_db, sw_rise, sw_fall, changed);
      end
    end
  endtask

  task automatic test_release_ff();
    logic [7:0] edb, er;
    logic       ec;
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      edb = (e >= 5) ? 8'hFF : 8'h00;
      er  = (e == 5) ? 8'hFF : 8'h00;
      ec  = (e == 5);
      checks++;
      if ({sw_db, sw_rise, sw_fall, changed} !== {edb, er, 8'h00, ec}) begin
        errors++;
        $display("FAIL release e=%0d db=%h rise=%h fall=%h chg=%b expected db=%h rise=%h fall=00 chg=%b",
                 e, sw_db, sw_rise, sw_fall, changed, edb, er, ec);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [7:0] edb, er;
    logic       ec;
    sw = 8'h00;
    for (int e = 0; e < 8; e++) tick();
    checks++;
    if (sw_db !== 8'h00) begin
      errors++;
      $display("FAIL settle_low db=%h expected 00", sw_db);
    end
    sw = 8'h08;
    for (int e = 0; e < 8; e++) begin
      tick();
      edb = (e >= 5) ? 8'h08 : 8'h00;
      er  = (e == 5) ? 8'h08 : 8'h00;
      ec  = (e == 5);
      checks++;
      if ({sw_db, sw_rise, sw_fall, changed} !== {edb, er, 8'h00, ec}) begin
        errors++;
        $display("FAIL press e=%0d db=%h rise=%h fall=%h chg=%b expected db=%h rise=%h fall=00 chg=%b",
                 e, sw_db, sw_rise, sw_fall, changed, edb, er, ec);
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] edb, er;
    logic       ec;
    // sw[0] sampled 1,0,1,0 on edges 0..3, then 1 from edge 4 onward.
    for (int e = 0; e < 12; e++) begin
      sw[0] = (e >= 4) ? 1'b1 : ((e % 2) == 0);
      tick();
      edb = (e >= 9) ? 8'h09 : 8'h08;
      er  = (e == 9) ? 8'h01 : 8'h00;
      ec  = (e == 9);
      checks++;
      if ({sw_db, sw_rise, sw_fall, changed} !== {edb, er, 8'h00, ec}) begin
        errors++;
        $display("FAIL bounce e=%0d db=%h rise=%h fall=%h chg=%b expected db=%h rise=%h fall=00 chg=%b",
                 e, sw_db, sw_rise, sw_fall, changed, edb, er, ec);
      end
    end
  endtask

  task automatic test_glitch();
    for (int e = 0; e < 10; e++) begin
      sw[7] = (e < 3);
      tick();
      checks++;
      if ({sw_db, sw_rise, sw_fall, changed} !== {8'h09, 8'h00, 8'h00, 1'b0}) begin
        errors++;
        $display("FAIL glitch e=%0d db=%h rise=%h fall=%h chg=%b expected db=09 rise=00 fall=00 chg=0",
                 e, sw_db, sw_rise, sw_fall, changed);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] edb, er, ef;
    logic       ec;
    sw = 8'h0F;
    for (int e = 0; e < 8; e++) tick();
    checks++;
    if (sw_db !== 8'h0F) begin
      errors++;
      $display("FAIL settle_0f db=%h expected 0f", sw_db);
    end
    sw = 8'hF0;
    for (int e = 0; e < 8; e++) begin
      tick();
      edb = (e >= 5) ? 8'hF0 : 8'h0F;
      er  = (e == 5) ? 8'hF0 : 8'h00;
      ef  = (e == 5) ? 8'h0F : 8'h00;
      ec  = (e == 5);
      checks++;
      if ({sw_db, sw_rise, sw_fall, changed} !== {edb, er, ef, ec}) begin
        errors++;
        $display("FAIL simul e=%0d db=%h rise=%h fall=%h chg=%b expected db=%h rise=%h fall=%h chg=%b",
                 e, sw_db, sw_rise, sw_fall, changed, edb, er, ef, ec);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [7:0] edb, er;
    logic       ec;
    sw = 8'hFF;
    for (int e = 0; e < 4; e++) begin
      tick();
      checks++;
      if ({sw_db, sw_rise, sw_fall, changed} !== {8'hF0, 8'h00, 8'h00, 1'b0}) begin
        errors++;
        $display("FAIL midcount e=%0d db=%h rise=%h fall=%h chg=%b expected db=f0 quiet",
                 e, sw_db, sw_rise, sw_fall, changed);
      end
    end
    rst = 1'b1;
    for (int e = 0; e < 2; e++) begin
      tick();
      checks++;
      if ({sw_db, sw_rise, sw_fall, changed} !== 25'd0) begin
        errors++;
        $display("FAIL midreset e=%0d db=%h rise=%h fall=%h chg=%b expected all 0",
                 e, sw_db, sw_rise, sw_fall, changed);
      end
    end
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      edb = (e >= 5) ? 8'hFF : 8'h00;
      er  = (e == 5) ? 8'hFF : 8'h00;
      ec  = (e == 5);
      checks++;
      if ({sw_db, sw_rise, sw_fall, changed} !== {edb, er, 8'h00, ec}) begin
        errors++;
        $display("FAIL after_midreset e=%0d db=%h rise=%h fall=%h chg=%b expected db=%h rise=%h fall=00 chg=%b",
                 e, sw_db, sw_rise, sw_fall, changed, edb, er, ec);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    sw  = 8'hFF;
    test_reset();
    test_release_ff();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
